uart_tx_arbiter: RTL and testbench

- Parametrised N-channel arbiter merging byte streams (SPI decoder, user command parser, future sources) onto the single UART transmitter.
- Successor to the fixed two-source spi/user pending-register arbitration in top.
- Adds a per-channel FIFO, fixed-priority or round-robin grant, a source-channel tag, and sticky per-channel overflow flags.
- Sits between the byte producers and uart_tx_fifo.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter_byte_fifo.sv | 53 +++++
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared sizing helper and grant-mode constants.
//   clog2_min1 : ceil(log2(n)), never less than 1 (channel tag / pointer widths)
//   MODE_FIXED : lowest-index non-empty channel wins
//   MODE_RR    : round-robin starting after the last granted channel
package uart_tx_arbiter_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-producer side and UART side of the arbiter.
//   in_data/in_strobe/in_ready     : per-channel write port (channel i at [i*WIDTH +: WIDTH])
//   out_data/out_strobe/out_ch     : one-cycle byte pulse to the UART with its source channel
//   out_ready                      : downstream can take a byte
//   overflow/overflow_clear        : sticky per-channel drop flags and their clear
//   master = producers/UART, slave = arbiter
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
);
    localparam int CH_BITS = clog2_min1(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_strobe;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_strobe;
    logic [CH_BITS-1:0]      out_ch;
    logic                    out_ready;
    logic [NUM_CH-1:0]       overflow;
    logic [NUM_CH-1:0]       overflow_clear;

    modport master (
        output in_data, in_strobe, out_ready, overflow_clear,
        input  in_ready, out_data, out_strobe, out_ch, overflow
    );

    modport slave (
        input  in_data, in_strobe, out_ready, overflow_clear,
        output in_ready, out_data, out_strobe, out_ch, overflow
    );

endinterface

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// uart_tx_arbiter_byte_fifo: small circular byte queue for one arbiter channel.
//   clk, reset : clock, asynchronous active-high reset (empties the queue)
//   push_i     : write data_i; ignored when full
//   pop_i      : drop the head entry; ignored when empty
//   data_o     : head entry (valid when !empty_o)
//   empty_o    : queue holds nothing
//   count_o    : number of entries held (0..DEPTH)
module uart_tx_arbiter_byte_fifo
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 4,
    localparam int PTR_BITS = clog2_min1(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WIDTH-1:0]    data_i,
    output logic [WIDTH-1:0]    data_o,
    output logic                empty_o,
    output logic [PTR_BITS:0]   count_o
);
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_q, rd_q;
    logic [PTR_BITS:0]   count_q;
    logic                do_push, do_pop;

    // fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never makes room for a push into a full queue
    assign do_push = push_i && (count_q != (PTR_BITS+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_q];
    assign empty_o = count_q == '0;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (PTR_BITS+1)'(do_push) - (PTR_BITS+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges NUM_CH queued byte streams onto one UART byte port.
//   clk, reset : clock, asynchronous active-high reset (drops all queued bytes)
//   bus        : uart_tx_arbiter_if slave port
//                in_*       per-channel writes, in_ready = channel queue not full
//                out_*      registered one-cycle byte pulse with source channel tag
//                overflow   sticky per-channel drop flags, overflow_clear clears them
// Parameters: NUM_CH channels, WIDTH bits per byte, DEPTH entries per channel,
//             RR = MODE_FIXED (channel 0 highest) or MODE_RR (round-robin).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int RR     = MODE_FIXED
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int CH_BITS  = clog2_min1(NUM_CH);
    localparam int PTR_BITS = clog2_min1(DEPTH);

    logic [NUM_CH-1:0]  full, empty, pop;
    logic [WIDTH-1:0]   head  [NUM_CH];
    logic [PTR_BITS:0]  count [NUM_CH];
    logic [CH_BITS-1:0] scan, grant;
    logic               grant_valid, issue;
    logic [NUM_CH-1:0]  overflow_q, overflow_d;
    logic [WIDTH-1:0]   out_data_q;
    logic [CH_BITS-1:0] out_ch_q, last_grant_q;
    logic               out_strobe_q, holdoff_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        uart_tx_arbiter_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (bus.in_strobe[i]),
            .pop_i   (pop[i]),
            .data_i  (bus.in_data[i*WIDTH +: WIDTH]),
            .data_o  (head[i]),
            .empty_o (empty[i]),
            .count_o (count[i])
        );
        assign full[i] = count[i] == (PTR_BITS+1)'(DEPTH);
    end

    // Scan every channel once; fixed mode starts at 0, round-robin starts
    // just after the last granted channel. First non-empty hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        scan        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan = CH_BITS'(((RR == MODE_RR) ? int'(last_grant_q) + 1 + k : k) % NUM_CH);
            if (!grant_valid && !empty[scan]) begin
                grant       = scan;
                grant_valid = 1'b1;
            end
        end
    end

    // holdoff leaves one idle cycle after each strobe so the UART side can drop out_ready
    assign issue      = bus.out_ready && !holdoff_q && grant_valid;
    assign pop        = issue ? NUM_CH'(1) << grant : '0;
    assign overflow_d = (overflow_q & ~bus.overflow_clear) | (bus.in_strobe & full);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_strobe_q <= 1'b0;
            holdoff_q    <= 1'b0;
            overflow_q   <= '0;
            last_grant_q <= CH_BITS'(NUM_CH - 1);
        end else begin
            out_strobe_q <= issue;
            holdoff_q    <= issue;
            overflow_q   <= overflow_d;
            if (issue) begin
                out_data_q   <= head[grant];
                out_ch_q     <= grant;
                last_grant_q <= grant;
            end
        end
    end

    assign bus.in_ready   = ~full;
    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiters (2 ch fixed priority, 3 ch round-robin) driven by shared
// stimulus and compared every cycle against a queue-level reference model.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NI = 2, MAXC = 3, D = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [MAXC-1:0]   strb = '0, clr = '0;
    logic [MAXC*8-1:0] dat = '0;
    logic              ordy = 1'b0;
    int                total = 0, bad = 0, cyc = 0, nlog = 0, n0 = 0;
    logic [7:0]        log_d [64];
    int                log_t [64];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_CH(2), .WIDTH(8)) if0 ();
    uart_tx_arbiter_if #(.NUM_CH(3), .WIDTH(8)) if1 ();

    assign if0.in_data        = dat[15:0];
    assign if0.in_strobe      = strb[1:0];
    assign if0.out_ready      = ordy;
    assign if0.overflow_clear = clr[1:0];
    assign if1.in_data        = dat;
    assign if1.in_strobe      = strb;
    assign if1.out_ready      = ordy;
    assign if1.overflow_clear = clr;

    uart_tx_arbiter #(.NUM_CH(2), .WIDTH(8), .DEPTH(D), .RR(MODE_FIXED)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    uart_tx_arbiter #(.NUM_CH(3), .WIDTH(8), .DEPTH(D), .RR(MODE_RR)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    logic            stb_v [NI];
    logic [7:0]      dat_v [NI];
    logic [1:0]      ch_v  [NI];
    logic [MAXC-1:0] rdy_v [NI];
    logic [MAXC-1:0] ovf_v [NI];

    assign stb_v[0] = if0.out_strobe;
    assign stb_v[1] = if1.out_strobe;
    assign dat_v[0] = if0.out_data;
    assign dat_v[1] = if1.out_data;
    assign ch_v[0]  = {1'b0, if0.out_ch};
    assign ch_v[1]  = if1.out_ch;
    assign rdy_v[0] = {1'b0, if0.in_ready};
    assign rdy_v[1] = if1.in_ready;
    assign ovf_v[0] = {1'b0, if0.overflow};
    assign ovf_v[1] = if1.overflow;

    // reference model: per-channel queues held as arrays with a fill level
    int              nch [NI] = '{2, 3};
    int              rrm [NI] = '{0, 1};
    logic [7:0]      mq   [NI][MAXC][D];
    int              msz  [NI][MAXC];
    int              mhold[NI], mlast[NI], mch[NI];
    logic [MAXC-1:0] movf [NI];
    logic            mstb [NI];
    logic [7:0]      mdat [NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < MAXC; c++) msz[i][c] = 0;
            movf[i]  = '0;
            mhold[i] = 0;
            mlast[i] = nch[i] - 1;
            mstb[i]  = 1'b0;
            mdat[i]  = '0;
            mch[i]   = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int n, g, c;
            bit full_pre [MAXC];
            n = nch[i];
            g = -1;
            for (int k = 0; k < MAXC; k++) full_pre[k] = msz[i][k] == D;
            if (ordy && mhold[i] == 0)
                for (int k = 0; k < n; k++) begin
                    c = rrm[i] != 0 ? (mlast[i] + 1 + k) % n : k;
                    if (g < 0 && msz[i][c] > 0) g = c;
                end
            mstb[i]  = g >= 0;
            mhold[i] = g >= 0 ? 1 : 0;
            if (g >= 0) begin
                mdat[i]  = mq[i][g][0];
                mch[i]   = g;
                mlast[i] = g;
                for (int j = 0; j < D - 1; j++) mq[i][g][j] = mq[i][g][j+1];
                msz[i][g]--;
            end
            for (int k = 0; k < n; k++) begin
                if (clr[k]) movf[i][k] = 1'b0;
                if (strb[k]) begin
                    if (full_pre[k]) movf[i][k] = 1'b1;
                    else begin
                        mq[i][k][msz[i][k]] = dat[k*8 +: 8];
                        msz[i][k]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("strobe%0d", i), 32'(stb_v[i]), 32'(mstb[i]));
            if (mstb[i]) begin
                chk($sformatf("data%0d", i), 32'(dat_v[i]), 32'(mdat[i]));
                chk($sformatf("ch%0d", i), 32'(ch_v[i]), 32'(mch[i]));
            end
            for (int c = 0; c < nch[i]; c++) begin
                chk($sformatf("rdy%0d_%0d", i, c), 32'(rdy_v[i][c]), 32'(msz[i][c] < D));
                chk($sformatf("ovf%0d_%0d", i, c), 32'(ovf_v[i][c]), 32'(movf[i][c]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all();
        if (stb_v[1] && nlog < 64) begin
            log_d[nlog] = dat_v[1];
            log_t[nlog] = cyc;
            nlog++;
        end
        if (stb_v[0]) n0++;
        strb = '0;
        clr  = '0;
    endtask

    // reset asserted away from the clock edge; outputs must clear immediately
    task automatic reset_dut();
        strb  = '0;
        clr   = '0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_data0", 32'(dat_v[0]), 0);
        chk("rst_data1", 32'(dat_v[1]), 0);
        chk("rst_ch0", 32'(ch_v[0]), 0);
        chk("rst_ch1", 32'(ch_v[1]), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int j = 0; j < n; j++) begin
            ordy = $urandom_range(0, 3) != 0;
            strb = 3'($urandom) & 3'($urandom);
            dat  = 24'($urandom);
            clr  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : '0;
            step();
        end
    endtask

    initial begin
        logic [7:0] exp_rr [6];
        exp_rr = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
        #2;
        reset_dut();

        // same-cycle writes on ch0 and ch1: ch0 first at t+1, ch1 at t+3
        ordy = 1'b1;
        strb = 3'b011;
        dat  = {8'h00, 8'h41, 8'h55};
        step();
        step();
        chk("t1_strobe_a", 32'(if0.out_strobe), 1);
        chk("t1_data_a", 32'(if0.out_data), 32'h55);
        step();
        chk("t1_holdoff", 32'(if0.out_strobe), 0);
        step();
        chk("t1_data_b", 32'(if0.out_data), 32'h41);
        chk("t1_ch_b", 32'(if0.out_ch), 1);

        // round-robin over three preloaded channels
        reset_dut();
        ordy = 1'b0;
        for (int j = 0; j < 2; j++) begin
            strb = 3'b111;
            dat  = {8'(8'h30 + j), 8'(8'h20 + j), 8'(8'h10 + j)};
            step();
        end
        ordy = 1'b1;
        nlog = 0;
        repeat (12) step();
        chk("rr_count", 32'(nlog), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 32'(log_d[k]), 32'(exp_rr[k]));
        for (int k = 0; k < 5; k++) chk($sformatf("rr_gap%0d", k), 32'(log_t[k+1] - log_t[k]), 2);

        // five writes into a depth-4 queue with the UART stalled
        ordy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            strb = 3'b001;
            dat  = {16'h0, 8'(8'hA0 + j)};
            step();
            if (j == 3) chk("ovf_full_rdy", 32'(if1.in_ready[0]), 0);
        end
        chk("ovf_set", 32'(if1.overflow[0]), 1);
        ordy = 1'b1;
        nlog = 0;
        repeat (10) step();
        chk("ovf_drain_count", 32'(nlog), 4);

        // full queue: pop and push in one cycle drops the push; set beats clear
        clr = 3'b111;
        step();
        ordy = 1'b0;
        repeat (4) begin
            strb = 3'b001;
            dat  = 24'($urandom);
            step();
        end
        ordy = 1'b1;
        strb = 3'b001;
        dat  = 24'h0000EE;
        step();
        chk("pp_ovf", 32'(if0.overflow[0]), 1);
        ordy = 1'b0;
        strb = 3'b001;
        step();
        strb = 3'b001;
        clr  = 3'b001;
        step();
        chk("clr_vs_set", 32'(if0.overflow[0]), 1);
        clr = 3'b001;
        step();
        chk("clr_alone", 32'(if0.overflow[0]), 0);
        ordy = 1'b1;
        repeat (10) step();

        // out_ready low for three cycles in the middle of a burst
        ordy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            strb = 3'b011;
            dat  = 24'($urandom);
            step();
        end
        ordy = 1'b1;
        repeat (3) step();
        ordy = 1'b0;
        repeat (3) step();
        ordy = 1'b1;
        repeat (14) step();

        // reset with bytes still queued
        ordy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            strb = 3'b111;
            dat  = 24'($urandom);
            step();
        end
        reset_dut();
        chk("rst_rdy_all", 32'(if1.in_ready), 32'h7);
        chk("rst_ovf_all", 32'(if1.overflow), 0);
        ordy = 1'b1;
        nlog = 0;
        n0   = 0;
        repeat (5) step();
        chk("rst_no_out1", 32'(nlog), 0);
        chk("rst_no_out0", 32'(n0), 0);

        rand_phase(400);
        reset_dut();
        rand_phase(300);
        ordy = 1'b1;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
